// File: rtl/dram_responder.sv
// dram_responder: on-chip word RAM behind the memory controller's DRAM port, zero-filled after
// reset and read through a READ_LAT-deep registered pipeline. Optional macro: WRITE_PROTECT_EN.
module dram_responder #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 16,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
`ifdef WRITE_PROTECT_EN
  , parameter int unsigned WP_LIMIT = 32'h0000_0100
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [DATA_W-1:0] dram_data,
  output logic [DATA_W-1:0] dram_dq,
  output logic              rd_valid,
  output logic              ready
`ifdef WRITE_PROTECT_EN
  , output logic            wr_reject
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
    $error("dram_responder: READ_LAT must be in 1..3");
  end

  typedef enum logic {FILL, RUN} state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              fill_we;
  logic              user_we;
  logic              run_rd;
  logic              reject_now;

  logic [READ_LAT-1:0] s_valid;
  logic [DATA_W-1:0]   s_data [READ_LAT];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == FILL) fill_cnt <= fill_cnt + ADDR_W'(1);
    end
  end

  // Without clearing, FILL is a single settling clock before RUN.
  always_comb begin
    next_state = state;
    case (state)
      FILL: if (CLEAR_ON_RESET == 0 || fill_cnt == '1) next_state = RUN;
      RUN:  next_state = RUN;
      default: next_state = FILL;
    endcase
  end

  always_comb begin
    fill_we    = (state == FILL) && (CLEAR_ON_RESET != 0);
    run_rd     = (state == RUN);
    reject_now = 1'b0;
`ifdef WRITE_PROTECT_EN
    reject_now = run_rd && we && (32'(dram_addr) < WP_LIMIT);
`endif
    user_we    = run_rd && we && !reject_now;
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (fill_we)      mem[fill_cnt]  <= '0;
      else if (user_we) mem[dram_addr] <= dram_data;
    end
  end

  // Stage 0 is the RAM read register; bubbles carry zero data so dram_dq is 0 outside RUN.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_valid <= '0;
      for (int i = 0; i < READ_LAT; i++) s_data[i] <= '0;
    end else begin
      s_valid[0] <= run_rd;
      if (!run_rd)      s_data[0] <= '0;
      else if (user_we) s_data[0] <= dram_data;
      else              s_data[0] <= mem[dram_addr];
      for (int i = 1; i < READ_LAT; i++) begin
        s_valid[i] <= s_valid[i-1];
        s_data[i]  <= s_data[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready <= 1'b0;
`ifdef WRITE_PROTECT_EN
      wr_reject <= 1'b0;
`endif
    end else begin
      ready <= (next_state == RUN);
`ifdef WRITE_PROTECT_EN
      wr_reject <= reject_now;
`endif
    end
  end

  assign dram_dq  = s_data[READ_LAT-1];
  assign rd_valid = s_valid[READ_LAT-1];

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: drives two responders (clearing/latency 1 and retaining/latency 3) with one
// stimulus stream and checks them against a reference memory model through per-DUT queues.
module tb_dram_responder;

  localparam int AW = 4;
  localparam int DW = 16;
`ifdef WRITE_PROTECT_EN
  localparam int WP = 4;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] dram_addr = '0;
  logic [DW-1:0] dram_data = '0;
  logic [DW-1:0] dq_a, dq_b;
  logic          valid_a, valid_b, ready_a, ready_b;
`ifdef WRITE_PROTECT_EN
  logic          rej_a, rej_b;
`endif

  dram_responder #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .CLEAR_ON_RESET(1)
`ifdef WRITE_PROTECT_EN
    , .WP_LIMIT(WP)
`endif
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .we(we), .dram_addr(dram_addr), .dram_data(dram_data),
    .dram_dq(dq_a), .rd_valid(valid_a), .ready(ready_a)
`ifdef WRITE_PROTECT_EN
    , .wr_reject(rej_a)
`endif
  );

  dram_responder #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .CLEAR_ON_RESET(0)
`ifdef WRITE_PROTECT_EN
    , .WP_LIMIT(WP)
`endif
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .we(we), .dram_addr(dram_addr), .dram_data(dram_data),
    .dram_dq(dq_b), .rd_valid(valid_b), .ready(ready_b)
`ifdef WRITE_PROTECT_EN
    , .wr_reject(rej_b)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          valid;
    logic          known;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] mdl_mem   [2][16];
  logic          mdl_known [2][16];
  int            edge_n    [2];
  logic          exp_ready [2];
  logic          exp_rej   [2];
  int            errors = 0;
  int            checks = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int fill_edges(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic logic is_prot(input logic [AW-1:0] a);
`ifdef WRITE_PROTECT_EN
    return 32'(a) < WP;
`else
    return (a != a);
`endif
  endfunction

  task automatic pushExp(input int d, input exp_t e);
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Reference behaviour of one DUT at one rising edge, using the inputs held across that edge.
  task automatic modelEdge(input int d);
    exp_t e;
    logic run;
    if (!reset_n) begin
      edge_n[d] = 0;
      if (d == 0) qa.delete();
      else        qb.delete();
      e = '{valid: 1'b0, known: 1'b1, data: '0};
      for (int i = 0; i < lat(d); i++) pushExp(d, e);
      exp_ready[d] = 1'b0;
      exp_rej[d]   = 1'b0;
    end else begin
      run = (edge_n[d] >= fill_edges(d));
      e = '{valid: 1'b0, known: 1'b1, data: '0};
      if (!run) begin
        if (d == 0) begin
          mdl_mem[d][edge_n[d]]   = '0;
          mdl_known[d][edge_n[d]] = 1'b1;
        end
      end else if (we && !is_prot(dram_addr)) begin
        e = '{valid: 1'b1, known: 1'b1, data: dram_data};
        mdl_mem[d][dram_addr]   = dram_data;
        mdl_known[d][dram_addr] = 1'b1;
      end else begin
        e = '{valid: 1'b1, known: mdl_known[d][dram_addr], data: mdl_mem[d][dram_addr]};
      end
      exp_rej[d]   = run && we && is_prot(dram_addr);
      exp_ready[d] = (edge_n[d] >= fill_edges(d) - 1);
      pushExp(d, e);
      if (edge_n[d] < 1000) edge_n[d]++;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t ea, eb;
    ea = qa.pop_front();
    eb = qb.pop_front();
    checkValue("a_rd_valid", 32'(valid_a), 32'(ea.valid));
    checkValue("a_ready", 32'(ready_a), 32'(exp_ready[0]));
    if (ea.known) checkValue("a_dram_dq", 32'(dq_a), 32'(ea.data));
    checkValue("b_rd_valid", 32'(valid_b), 32'(eb.valid));
    checkValue("b_ready", 32'(ready_b), 32'(exp_ready[1]));
    if (eb.known) checkValue("b_dram_dq", 32'(dq_b), 32'(eb.data));
`ifdef WRITE_PROTECT_EN
    checkValue("a_wr_reject", 32'(rej_a), 32'(exp_rej[0]));
    checkValue("b_wr_reject", 32'(rej_b), 32'(exp_rej[1]));
`endif
  endtask

  task automatic applyStimulus(input logic rst_n, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] dat);
    reset_n   = rst_n;
    we        = w;
    dram_addr = a;
    dram_data = dat;
    @(posedge clock);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkOutput();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      edge_n[d] = 0;
      exp_ready[d] = 1'b0;
      exp_rej[d] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        mdl_mem[d][i] = '0;
        mdl_known[d][i] = 1'b0;
      end
    end

    $display("[TB] reset and initial fill");
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, AW'(i), 16'hDEAD);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, AW'(i), 16'h0);

    $display("[TB] write then read, write-first");
    applyStimulus(1'b1, 1'b1, 4'd5, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 4'd5, 16'h0);
    applyStimulus(1'b1, 1'b1, 4'd9, 16'h1234);
    applyStimulus(1'b1, 1'b0, 4'd9, 16'h0);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0);

    $display("[TB] fill every word, repeated write to one address");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, AW'(i), 16'hA000 + 16'(i));
    applyStimulus(1'b1, 1'b1, 4'd3, 16'hAAAA);
    applyStimulus(1'b1, 1'b1, 4'd2, 16'h5A5A);
    applyStimulus(1'b1, 1'b1, 4'd7, 16'h1111);
    applyStimulus(1'b1, 1'b1, 4'd7, 16'h2222);
    applyStimulus(1'b1, 1'b1, 4'd4, 16'hFFFF);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, AW'(i), 16'h0);

    $display("[TB] reset during fill");
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, AW'(i), 16'h0);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, AW'(15 - i), 16'hC0DE);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, AW'(i), 16'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                    16'($urandom_range(0, 65535)));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, AW'(i), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
